// File: rtl/dmem_bridge.sv
// dmem_bridge: blocking bridge from the core dsram port to a
// valid/ready memory bus, one transaction in flight.
module dmem_bridge #(
   parameter int unsigned TIMEOUT_CYC = 256,
   parameter logic [63:0] ERR_RDATA   = 64'hdead_beef_dead_beef
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dsram_e,
   input  logic        dsram_we,
   input  logic [63:0] dsram_addr,
   input  logic [63:0] dsram_wdata,
   input  logic [7:0]  dsram_sel,
   output logic [63:0] dsram_rdata,
   output logic        stall,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [63:0] mem_req_addr,
   output logic [63:0] mem_req_wdata,
   output logic [7:0]  mem_req_wmask,
   input  logic        mem_rsp_valid,
   input  logic [63:0] mem_rsp_rdata,
   output logic        err_timeout,
   output logic [31:0] acc_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } state_t;

   state_t      state;
   logic [31:0] to_cnt;
   logic        to_hit;

   // limit reached on this WAIT cycle; a zero limit never fires
   assign to_hit = (TIMEOUT_CYC != 0) &&
                   (to_cnt == 32'(TIMEOUT_CYC - 1));

   // freeze the core the same cycle it raises a request
   assign stall = (state == IDLE) ? dsram_e : (state != DONE);

   // request is offered for the whole REQ state
   assign mem_req_valid = (state == REQ);

   // request latch, response capture, timeout and access count
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         to_cnt        <= '0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_wmask <= '0;
         dsram_rdata   <= '0;
         err_timeout   <= 1'b0;
         acc_cnt       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (dsram_e) begin
                  mem_req_we    <= dsram_we;
                  mem_req_addr  <= dsram_addr;
                  mem_req_wdata <= dsram_wdata;
                  mem_req_wmask <= dsram_we ? dsram_sel : 8'h00;
                  to_cnt        <= '0;
                  state         <= REQ;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (mem_rsp_valid) begin
                  dsram_rdata <= mem_rsp_rdata;
                  acc_cnt     <= acc_cnt + 32'd1;
                  state       <= DONE;
               end else if (to_hit) begin
                  dsram_rdata <= ERR_RDATA;
                  err_timeout <= 1'b1;
                  acc_cnt     <= acc_cnt + 32'd1;
                  state       <= DONE;
               end else begin
                  to_cnt <= to_cnt + 32'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
